// File: rtl/rr_split_arbiter.sv
// Registered round-robin bus arbiter with one outstanding split transfer.
// Optional per-tenure hold limit and forced release is enabled by defining BUS_TIMEOUT_EN.
module rr_split_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int MAX_HOLD  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_MASTERS-1:0]         req,
  output logic [N_MASTERS-1:0]         grant,
  output logic [$clog2(N_MASTERS)-1:0] m_sel,
  output logic                         bus_busy,
  input  logic                         split,
  input  logic                         split_req,
  output logic                         split_grant,
  output logic                         split_pend,
  output logic                         timeout
);
  localparam int IW = $clog2(N_MASTERS);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t               state_q;
  logic [N_MASTERS-1:0] grant_q;
  logic [IW-1:0]        owner_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        split_idx_q;
  logic                 split_grant_q;
  logic                 split_pend_q;
  logic                 split_own_q;

  logic [N_MASTERS-1:0] parked;
  logic [N_MASTERS-1:0] eligible;
  logic                 rr_found_d;
  logic [IW-1:0]        rr_idx_d;
  logic [IW-1:0]        cand;

  function automatic logic [N_MASTERS-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign parked = split_pend_q ? onehot(split_idx_q) : '0;

`ifdef BUS_TIMEOUT_EN
  localparam int HW = ($clog2(MAX_HOLD + 1) > 8) ? $clog2(MAX_HOLD + 1) : 8;

  logic [HW-1:0]        hold_q;
  logic [N_MASTERS-1:0] tmask_q;
  logic                 timeout_q;

  assign eligible = req & ~parked & ~tmask_q;
  assign timeout  = timeout_q;
`else
  localparam int unused_max_hold = MAX_HOLD;

  assign eligible = req & ~parked;
  assign timeout  = 1'b0;
`endif

  // Search starts one past the last RR winner and wraps around.
  always_comb begin
    rr_found_d = 1'b0;
    rr_idx_d   = '0;
    cand       = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = IW'((int'(ptr_q) + k) % N_MASTERS);
      if (!rr_found_d && eligible[cand]) begin
        rr_found_d = 1'b1;
        rr_idx_d   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      ptr_q         <= '0;
      split_idx_q   <= '0;
      split_grant_q <= 1'b0;
      split_pend_q  <= 1'b0;
      split_own_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      hold_q        <= '0;
      tmask_q       <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      split_grant_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      timeout_q     <= 1'b0;
      tmask_q       <= tmask_q & req;
`endif
      case (state_q)
        IDLE: begin
          if (split_pend_q && split_req) begin
            // Resuming the parked master leaves the RR pointer untouched.
            grant_q       <= onehot(split_idx_q);
            owner_q       <= split_idx_q;
            split_grant_q <= 1'b1;
            split_own_q   <= 1'b1;
            state_q       <= OWNED;
`ifdef BUS_TIMEOUT_EN
            hold_q        <= HW'(1);
`endif
          end else if (rr_found_d) begin
            grant_q     <= onehot(rr_idx_d);
            owner_q     <= rr_idx_d;
            ptr_q       <= rr_idx_d;
            split_own_q <= 1'b0;
            state_q     <= OWNED;
`ifdef BUS_TIMEOUT_EN
            hold_q      <= HW'(1);
`endif
          end
        end
        OWNED: begin
          if (split && !split_pend_q) begin
            split_pend_q <= 1'b1;
            split_idx_q  <= owner_q;
            grant_q      <= '0;
            state_q      <= IDLE;
          end else if (!req[owner_q]) begin
            grant_q <= '0;
            state_q <= IDLE;
            if (split_own_q) split_pend_q <= 1'b0;
          end
`ifdef BUS_TIMEOUT_EN
          else if (hold_q == HW'(MAX_HOLD)) begin
            grant_q          <= '0;
            state_q          <= IDLE;
            timeout_q        <= 1'b1;
            tmask_q[owner_q] <= 1'b1;
            if (split_own_q) split_pend_q <= 1'b0;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign m_sel       = owner_q;
  assign bus_busy    = |grant_q;
  assign split_grant = split_grant_q;
  assign split_pend  = split_pend_q;
endmodule

// File: tb/tb_rr_split_arbiter.sv
// Scoreboard bench for rr_split_arbiter (N_MASTERS=2, MAX_HOLD=8); the stimulus queues expected
// output changes with their due cycle, and a monitor checks every change the DUT presents.
module tb_rr_split_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] grant;
  logic [0:0] m_sel;
  logic       bus_busy;
  logic       split = 1'b0;
  logic       split_req = 1'b0;
  logic       split_grant;
  logic       split_pend;
  logic       timeout;

  rr_split_arbiter #(.N_MASTERS(2), .MAX_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .m_sel(m_sel),
    .bus_busy(bus_busy), .split(split), .split_req(split_req),
    .split_grant(split_grant), .split_pend(split_pend), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         due;
    logic [1:0] g;
    logic       ms;
    logic       sg;
    logic       sp;
    logic       to;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  bit         mon_en  = 1'b0;
  logic [6:0] snap;
  logic [6:0] prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input string nm, input int d, input logic [1:0] g, input logic ms,
                           input logic sg, input logic sp, input logic to);
    exp_t e;
    e.name = nm; e.due = cyc + d; e.g = g; e.ms = ms; e.sg = sg; e.sp = sp; e.to = to;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end else begin
      $display("[TB] ok %s = %0h", nm, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any change of the output bundle is one transaction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    snap = {grant, m_sel, bus_busy, split_grant, split_pend, timeout};
    if (mon_en && snap !== prev) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: cyc=%0d grant=%b m_sel=%0d busy=%b sg=%b sp=%b to=%b",
                 cyc, grant, m_sel, bus_busy, split_grant, split_pend, timeout);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.due || grant !== e.g || m_sel !== e.ms || bus_busy !== (|e.g) ||
            split_grant !== e.sg || split_pend !== e.sp || timeout !== e.to) begin
          n_fail++;
          $display("FAIL %s: got cyc=%0d grant=%b m_sel=%0d busy=%b sg=%b sp=%b to=%b; want cyc=%0d grant=%b m_sel=%0d busy=%b sg=%b sp=%b to=%b",
                   e.name, cyc, grant, m_sel, bus_busy, split_grant, split_pend, timeout,
                   e.due, e.g, e.ms, |e.g, e.sg, e.sp, e.to);
        end else begin
          $display("[TB] ok %s: cyc=%0d grant=%b m_sel=%0d sg=%b sp=%b to=%b",
                   e.name, cyc, grant, m_sel, split_grant, split_pend, timeout);
        end
      end
    end
    prev = snap;
  end

  initial begin
    step(2);
    chk("reset_grant", 8'(grant), 8'h0);
    chk("reset_m_sel", 8'(m_sel), 8'h0);
    chk("reset_bus_busy", 8'(bus_busy), 8'h0);
    chk("reset_split_grant", 8'(split_grant), 8'h0);
    chk("reset_split_pend", 8'(split_pend), 8'h0);
    chk("reset_timeout", 8'(timeout), 8'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step(1);

    // Single master request and release.
    req = 2'b01; expect_ev("t1_grant_m0", 1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    req = 2'b00; expect_ev("t1_release_m0", 1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    req = 2'b10; expect_ev("pre_grant_m1", 1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2);
    req = 2'b00; expect_ev("pre_release_m1", 1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);

    // Both requesting: alternate with a dead cycle between owners.
    req = 2'b11; expect_ev("t2_grant_m0", 1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    req = 2'b10; expect_ev("t2_dead_1", 1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    req = 2'b11; expect_ev("t2_grant_m1", 1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    step(3);
    req = 2'b01; expect_ev("t2_dead_2", 1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    req = 2'b11; expect_ev("t2_grant_m0_again", 1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    req = 2'b00; expect_ev("t2_release", 1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);

    // Split m0, serve m1, resume m0 after m1 releases.
    req = 2'b01; expect_ev("t3_grant_m0", 1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    split = 1'b1; expect_ev("t3_split_park", 1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    split = 1'b0; req = 2'b11;
    expect_ev("t3_grant_m1", 1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1);
    split_req = 1'b1;
    step(2);
    req = 2'b01;
    expect_ev("t3_m1_release", 1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_ev("t3_split_regrant", 2, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_ev("t3_split_grant_end", 3, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    step(2);
    split_req = 1'b0;
    step(1);
    split = 1'b1;    // second split while one is pending: ignored
    step(1);
    split = 1'b0;
    step(1);
    req = 2'b00; expect_ev("t4_split_release_clears", 1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    split_req = 1'b1;   // nothing parked: no grant
    step(2);
    split_req = 1'b0;
    chk("t4_stray_split_req_grant", 8'(grant), 8'h0);

    // Asynchronous reset while m1 owns and m0 is parked.
    req = 2'b01; expect_ev("t5_grant_m0", 1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    split = 1'b1; expect_ev("t5_split_park", 1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1);
    split = 1'b0; req = 2'b11;
    expect_ev("t5_grant_m1", 1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1);
    rst_n = 1'b0; req = 2'b00;
    expect_ev("t5_async_reset", 1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t5_async_grant", 8'(grant), 8'h0);
    chk("t5_async_m_sel", 8'(m_sel), 8'h0);
    chk("t5_async_split_pend", 8'(split_pend), 8'h0);
    chk("t5_async_bus_busy", 8'(bus_busy), 8'h0);
    step(2);
    rst_n = 1'b1;
    step(1);
    req = 2'b01; expect_ev("t5_regrant_m0", 1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    req = 2'b00; expect_ev("t5_release", 1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);

`ifdef BUS_TIMEOUT_EN
    // m0 holds req for 20 cycles; forced release after 8 owned cycles.
    req = 2'b01;
    expect_ev("t6_grant_m0", 1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_ev("t6_timeout", 9, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_ev("t6_grant_m1", 10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2);
    req = 2'b11;
    step(10);
    req = 2'b01; expect_ev("t6_m1_release", 1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8);
    req = 2'b00;
    step(1);
    req = 2'b01; expect_ev("t6_m0_unmasked", 1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    req = 2'b00; expect_ev("t6_release", 1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
`endif

    step(3);
    chk("pending_expectations", 8'(exp_q.size()), 8'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
